// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage with the
// carry registered between stages, valid/ready handshake with global stall.
module pipelined_add_sub #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int unsigned STAGES = WIDTH / CHUNK;
   localparam int unsigned LAST   = STAGES - 1;

   // Stage k's register set; index LAST doubles as the output register so
   // accept-to-out_valid latency is exactly STAGES cycles.
   logic [WIDTH-1:0] r_a [STAGES];
   logic [WIDTH-1:0] r_b [STAGES];
   logic [WIDTH-1:0] r_s [STAGES];
   logic             r_c [STAGES];
   logic             r_v [STAGES];
   logic             r_ovf;
   logic             r_zero;

   // Stage inputs (operand skew, carry, partial sum, valid)
   logic [WIDTH-1:0] op_a [STAGES];
   logic [WIDTH-1:0] op_b [STAGES];
   logic [WIDTH-1:0] op_s [STAGES];
   logic             op_c [STAGES];
   logic             op_v [STAGES];

   // Stage results
   logic [CHUNK:0]   slice [STAGES];
   logic [WIDTH-1:0] nx_a  [STAGES];
   logic [WIDTH-1:0] nx_b  [STAGES];
   logic [WIDTH-1:0] nx_s  [STAGES];
   logic             nx_c  [STAGES];
   logic             nx_v  [STAGES];
   logic             nx_ovf;
   logic             nx_zero;

   logic advance;

   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign out_valid = r_v[LAST];
   assign out_sum   = r_s[LAST];
   assign out_cout  = r_c[LAST];
   assign out_ovf   = r_ovf;
   assign out_zero  = r_zero;

   // Select each stage's inputs: ports for stage 0 (with subtract inversion), previous register otherwise
   always_comb begin
      op_a[0] = in_a;
      op_b[0] = in_sub ? ~in_b : in_b;
      op_c[0] = in_sub ? 1'b1 : in_cin;
      op_s[0] = '0;
      op_v[0] = in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
         op_a[k] = r_a[k-1];
         op_b[k] = r_b[k-1];
         op_c[k] = r_c[k-1];
         op_s[k] = r_s[k-1];
         op_v[k] = r_v[k-1];
      end
   end

   // Add slice k, merge it into the forwarded partial sum, clear consumed operand slices
   always_comb begin
      for (int unsigned k = 0; k < STAGES; k++) begin
         slice[k] = {1'b0, op_a[k][k*CHUNK +: CHUNK]}
                  + {1'b0, op_b[k][k*CHUNK +: CHUNK]}
                  + (CHUNK+1)'(op_c[k]);
         nx_s[k] = op_s[k];
         nx_s[k][k*CHUNK +: CHUNK] = slice[k][CHUNK-1:0];
         nx_a[k] = op_a[k];
         nx_a[k][k*CHUNK +: CHUNK] = '0;
         nx_b[k] = op_b[k];
         nx_b[k][k*CHUNK +: CHUNK] = '0;
         nx_c[k] = slice[k][CHUNK];
         nx_v[k] = op_v[k];
      end
   end

   // Status flags from the final stage; carry-in XOR carry-out of the MSB is
   // computed in the equivalent form "same-sign operands, different-sign sum".
   always_comb begin
      nx_zero = (nx_s[LAST] == '0);
      nx_ovf  = (op_a[LAST][WIDTH-1] == op_b[LAST][WIDTH-1])
             && (nx_s[LAST][WIDTH-1] != op_a[LAST][WIDTH-1]);
   end

   // All stages and the output register shift together whenever the output is free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
            r_c[k] <= 1'b0;
            r_v[k] <= 1'b0;
         end
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
      end else if (advance) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_a[k] <= nx_a[k];
            r_b[k] <= nx_b[k];
            r_s[k] <= nx_s[k];
            r_c[k] <= nx_c[k];
            r_v[k] <= nx_v[k];
         end
         r_ovf  <= nx_ovf;
         r_zero <= nx_zero;
      end
   end

endmodule
